// File: rtl/io_test_mux_n.sv
// io_test_mux_n: test-signal router for the on-chip scope.
// CMuxCnt lane muxes each pick one CLaneWidth-bit lane of ATestIn. Selects are
// written into shadow registers over the debug IO bus and copied to the active
// set by a single commit, so the scope never observes a partial switch.
// A freeze bit holds the registered output.
module io_test_mux_n #(
  parameter logic [15:0] CAddrBase  = 16'h0000,
  parameter int          CInWidth   = 512,
  parameter int          CLaneWidth = 8,
  parameter int          CMuxCnt    = 16,
  parameter int          CSelWidth  = 6
) (
  input  logic                          AClkH,
  input  logic                          AResetH,
  input  logic                          AClkHEn,
  input  logic [15:0]                   AIoAddr,
  input  logic [63:0]                   AIoMosi,
  input  logic [3:0]                    AIoWrSize,
  input  logic [3:0]                    AIoRdSize,
  output logic [63:0]                   AIoMiso,
  output logic                          AIoAddrAck,
  output logic                          AIoAddrErr,
  input  logic [CInWidth-1:0]           ATestIn,
  output logic [CMuxCnt*CLaneWidth-1:0] ATestOut
);

  localparam int CLaneCnt = CInWidth / CLaneWidth;

  logic [5:0]                   r_ptr;
  logic [CSelWidth-1:0]         r_shadow [CMuxCnt];
  logic [CSelWidth-1:0]         r_active [CMuxCnt];
  logic                         r_freeze;
  logic [CMuxCnt*CLaneWidth-1:0] r_out;

  logic [15:0]                  w_off;
  logic                         w_in_range;
  logic                         w_wr_byte;
  logic                         w_rd_byte;
  logic                         w_wr_ok;
  logic                         w_rd_ok;
  logic [5:0]                   w_ptr_inc;
  logic [CSelWidth-1:0]         w_act_at_ptr;
  logic [7:0]                   w_rd_data;
  logic [CMuxCnt*CLaneWidth-1:0] w_mux;
  logic                         w_unused;

  // Address decode: only the three registers above the base respond.
  assign w_off      = AIoAddr - CAddrBase;
  assign w_in_range = (AIoAddr >= CAddrBase) && (w_off <= 16'd2);
  assign w_wr_byte  = (AIoWrSize == 4'b0001);
  assign w_rd_byte  = (AIoRdSize == 4'b0001);
  assign w_wr_ok    = w_in_range && w_wr_byte;
  assign w_rd_ok    = w_in_range && w_rd_byte;

  assign AIoAddrAck = w_in_range && (w_wr_byte || w_rd_byte);
  assign AIoAddrErr = w_in_range && (((AIoWrSize != 4'b0000) && !w_wr_byte) ||
                                     ((AIoRdSize != 4'b0000) && !w_rd_byte));

  // Only the low data bits carry register content.
  assign w_unused = ^AIoMosi[63:6];

  assign w_ptr_inc = (r_ptr == 6'(CMuxCnt - 1)) ? 6'd0 : (r_ptr + 6'd1);

  // Active select of the mux addressed by the pointer, for SEL readback.
  always_comb begin
    w_act_at_ptr = '0;
    for (int m = 0; m < CMuxCnt; m++) begin
      w_act_at_ptr = w_act_at_ptr | ((r_ptr == 6'(m)) ? r_active[m] : '0);
    end
  end

  // Read data mux; zero whenever no valid byte read is in progress.
  always_comb begin
    w_rd_data = 8'h00;
    if (w_rd_ok) begin
      case (w_off[1:0])
        2'd0:    w_rd_data = {2'b00, r_ptr};
        2'd1:    w_rd_data = 8'(w_act_at_ptr);
        2'd2:    w_rd_data = {6'b000000, r_freeze, 1'b0};
        default: w_rd_data = 8'h00;
      endcase
    end else begin
      w_rd_data = 8'h00;
    end
  end

  assign AIoMiso = {56'd0, w_rd_data};

  // Lane selection per mux; selects beyond the last lane yield zero.
  always_comb begin
    w_mux = '0;
    for (int m = 0; m < CMuxCnt; m++) begin
      for (int k = 0; k < CLaneCnt; k++) begin
        w_mux[m*CLaneWidth +: CLaneWidth] = w_mux[m*CLaneWidth +: CLaneWidth] |
          ((r_active[m] == CSelWidth'(k)) ? ATestIn[k*CLaneWidth +: CLaneWidth]
                                          : {CLaneWidth{1'b0}});
      end
    end
  end

  // Register file, commit/freeze control and output register; output
  // sampling uses the pre-edge active set and freeze bit.
  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      r_ptr    <= 6'd0;
      r_freeze <= 1'b0;
      r_out    <= '0;
      for (int m = 0; m < CMuxCnt; m++) begin
        r_shadow[m] <= '0;
        r_active[m] <= '0;
      end
    end else if (AClkHEn) begin
      if (!r_freeze) begin
        r_out <= w_mux;
      end
      if (w_wr_ok) begin
        case (w_off[1:0])
          2'd0: begin
            if ({1'b0, AIoMosi[5:0]} < 7'(CMuxCnt)) begin
              r_ptr <= AIoMosi[5:0];
            end
          end
          2'd1: begin
            for (int m = 0; m < CMuxCnt; m++) begin
              if (r_ptr == 6'(m)) begin
                r_shadow[m] <= AIoMosi[CSelWidth-1:0];
              end
            end
            r_ptr <= w_ptr_inc;
          end
          2'd2: begin
            if (AIoMosi[0]) begin
              for (int m = 0; m < CMuxCnt; m++) begin
                r_active[m] <= r_shadow[m];
              end
            end
            r_freeze <= AIoMosi[1];
          end
          default: begin
            r_ptr <= r_ptr;
          end
        endcase
      end else if (w_rd_ok && (w_off[1:0] == 2'd1)) begin
        r_ptr <= w_ptr_inc;
      end
    end
  end

  assign ATestOut = r_out;

endmodule
